// File: rtl/vga_color_frame.sv
// 640x480@60 VGA timing generator with a solid-colour pixel stage.
// Colour index steps through an 8-entry palette on next/prev requests, applied only at frame start.
module vga_color_frame #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_PW       = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_PW       = 2,
  parameter int V_BP       = 33,
  parameter int INIT_COLOR = 7
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       next_pulse,
  input  logic       prev_pulse,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_PW + H_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_PW);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_PW + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_PW);

  typedef enum logic [1:0] {REQ_NONE, REQ_INC, REQ_DEC} req_t;

  logic       pix_en;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       frame_wrap;
  logic       active;
  req_t       pending;
  req_t       req_in;
  logic [2:0] color_idx;

  function automatic logic [11:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 12'h000;
      3'd1:    palette = 12'hF00;
      3'd2:    palette = 12'h0F0;
      3'd3:    palette = 12'h00F;
      3'd4:    palette = 12'hFF0;
      3'd5:    palette = 12'h0FF;
      3'd6:    palette = 12'hF0F;
      default: palette = 12'hFFF;
    endcase
  endfunction

  // Counters step on the pix_en phase, giving the 25 MHz pixel rate from the 50 MHz clock.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      pix_en <= 1'b0;
      hcnt   <= '0;
      vcnt   <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  assign frame_wrap = pix_en && (hcnt == H_LAST) && (vcnt == V_LAST);
  assign active     = (hcnt < H_VIS) && (vcnt < V_VIS);

  always_comb begin
    req_in = REQ_NONE;
    if (next_pulse && !prev_pulse) req_in = REQ_INC;
    else if (prev_pulse && !next_pulse) req_in = REQ_DEC;
  end

  // A request landing on the wrap clock becomes the pending one for the following frame.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      pending   <= REQ_NONE;
      color_idx <= 3'(INIT_COLOR);
    end else if (frame_wrap) begin
      case (pending)
        REQ_INC: color_idx <= color_idx + 3'd1;
        REQ_DEC: color_idx <= color_idx - 3'd1;
        default: color_idx <= color_idx;
      endcase
      pending <= req_in;
    end else if (req_in != REQ_NONE) begin
      pending <= req_in;
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      {VGA_R, VGA_G, VGA_B} <= 12'h000;
      VGA_HSYNC   <= 1'b1;
      VGA_VSYNC   <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= active ? palette(color_idx) : 12'h000;
      VGA_HSYNC   <= !((hcnt >= HS_START) && (hcnt < HS_END));
      VGA_VSYNC   <= !((vcnt >= VS_START) && (vcnt < VS_END));
      video_on    <= active;
      pixel_x     <= hcnt;
      pixel_y     <= vcnt;
      // Only the first of the two clocks spent on (0,0) carries the pulse.
      frame_start <= !pix_en && (hcnt == 10'd0) && (vcnt == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_color_frame.sv
// Scoreboard bench for vga_color_frame on a reduced raster: a pixel-index model predicts every
// registered output, a monitor pops and compares each clock.
module tb_vga_color_frame;

  localparam int HV = 16, HFP = 2, HPW = 4, HBP = 3;
  localparam int VV = 6,  VFP = 1, VPW = 2, VBP = 2;
  localparam int HT = HV + HFP + HPW + HBP;
  localparam int VT = VV + VFP + VPW + VBP;
  localparam int FRAME = HT * VT;
  localparam int FCLK  = 2 * FRAME;
  localparam int INIT  = 7;
  localparam logic [35:0] RESET_VEC = {12'h000, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0};

  logic       clk;
  logic       rst_n;
  logic       next_pulse;
  logic       prev_pulse;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;

  vga_color_frame #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_PW(HPW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_PW(VPW), .V_BP(VBP),
    .INIT_COLOR(INIT)
  ) dut (
    .CLK50MHZ(clk), .RST(rst_n), .next_pulse(next_pulse), .prev_pulse(prev_pulse),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HSYNC(vga_hsync), .VGA_VSYNC(vga_vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n      = 0;
  int m_color = INIT;
  int m_pend  = 0;
  int fc      = 0;
  bit table_on = 1'b0;
  bit post_rst_chk = 1'b0;
  logic [35:0] exp_q[$];
  int frame_tbl[7] = '{7, 0, 7, 7, 6, 5, 6};

  function automatic logic [11:0] pal(input int idx);
    logic [3:0] r, g, b;
    r = (idx == 1 || idx == 4 || idx == 6 || idx == 7) ? 4'hF : 4'h0;
    g = (idx == 2 || idx == 4 || idx == 5 || idx == 7) ? 4'hF : 4'h0;
    b = (idx == 3 || idx == 5 || idx == 6 || idx == 7) ? 4'hF : 4'h0;
    return {r, g, b};
  endfunction

  function automatic logic [35:0] dut_vec();
    return {vga_r, vga_g, vga_b, vga_hsync, vga_vsync, video_on, pixel_x, pixel_y, frame_start};
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Reference model: output after edge n shows pixel index (n-1)/2 of the frame.
  always @(posedge clk) begin
    if (rst_n) begin
      int p, hx, vy, req;
      logic von, hs, vs, fs;
      logic [11:0] rgb;
      n++;
      p   = ((n - 1) / 2) % FRAME;
      hx  = p % HT;
      vy  = p / HT;
      von = (hx < HV) && (vy < VV);
      rgb = von ? pal(m_color) : 12'h000;
      hs  = !((hx >= HV + HFP) && (hx < HV + HFP + HPW));
      vs  = !((vy >= VV + VFP) && (vy < VV + VFP + VPW));
      fs  = (p == 0) && ((n - 1) % 2 == 0);
      exp_q.push_back({rgb, hs, vs, von, 10'(hx), 10'(vy), fs});
      req = (next_pulse && !prev_pulse) ? 1 : ((prev_pulse && !next_pulse) ? -1 : 0);
      if ((n % 2 == 0) && ((n / 2) % FRAME == 0)) begin
        m_color = (m_color + m_pend + 8) % 8;
        m_pend  = req;
      end else if (req != 0) begin
        m_pend = req;
      end
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [35:0] e;
      logic [35:0] a;
      e = exp_q.pop_front();
      a = dut_vec();
      chk("pixel", a, e);
      if (e[0]) begin
        if (table_on && fc < 7) chk("frame_color", 36'(a[35:24]), 36'(pal(frame_tbl[fc])));
        if (post_rst_chk) begin
          chk("post_reset_color", 36'(a[35:24]), 36'(pal(INIT)));
          post_rst_chk = 1'b0;
        end
        fc++;
      end
    end
  end

  task automatic model_reset();
    n = 0;
    m_color = INIT;
    m_pend = 0;
  endtask

  task automatic drive(input int m);
    int fr, pos, r;
    fr  = m / FCLK;
    pos = m % FCLK;
    next_pulse = 1'b0;
    prev_pulse = 1'b0;
    case (fr)
      0: next_pulse = (pos == 200);
      1: prev_pulse = (pos == 300);
      2: begin next_pulse = (pos == 100); prev_pulse = (pos == 100); end
      3: begin
        next_pulse = (pos == 50) || (pos == 150) || (pos == 250);
        prev_pulse = (pos == 350);
      end
      4: prev_pulse = (pos == 400);
      5: next_pulse = (pos == 0);
      default: begin
        r = $urandom_range(0, 199);
        if (pos == 0 && $urandom_range(0, 3) == 0) r = $urandom_range(0, 2);
        next_pulse = (r == 0) || (r == 2);
        prev_pulse = (r == 1) || (r == 2);
      end
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    next_pulse = 1'b0;
    prev_pulse = 1'b0;
    model_reset();
    #100;
    chk("reset_state", dut_vec(), RESET_VEC);
    @(negedge clk);
    #2 rst_n = 1'b1;
    table_on = 1'b1;
    for (int c = 0; c < 30 * FCLK; c++) begin
      @(negedge clk);
      #2 drive(n + 1);
    end
    table_on = 1'b0;
    // Queue an increment, then pull reset on line 3 of the frame.
    for (int c = 0; c < 2 * (3 * HT + 5); c++) begin
      @(negedge clk);
      #2;
      next_pulse = (c == 10);
      prev_pulse = 1'b0;
    end
    @(negedge clk);
    #2;
    next_pulse = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1 chk("reset_async", dut_vec(), RESET_VEC);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("reset_hold", dut_vec(), RESET_VEC);
    end
    #1 rst_n = 1'b1;
    post_rst_chk = 1'b1;
    for (int c = 0; c < 2 * FCLK + 4; c++) @(negedge clk);
    #5;
    chk("queue_drained", 36'(exp_q.size()), 36'd0);
    chk("post_reset_frame_seen", 36'(post_rst_chk), 36'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
